// File: rtl/self_output_residual_requant.sv
`timescale 1ns/1ps
// self_output_residual_requant
//   Requantizes N-lane int32 accumulator beats (attention-output x W_self_output)
//   to int8 with a 32-bit multiplier and a rounding right shift. It then adds the
//   int8 residual stream and sends per-lane signed sums, framed by row, to the
//   self-output LayerNorm.
//
// Ports (top):
//   clk, rstn                    clock, asynchronous active-low reset
//   start                        run start pulse (IDLE only); latches requant_m/_e
//   requant_m[31:0], requant_e   unsigned multiplier, right-shift exponent (clamped to 63)
//   acc_t{data,valid,ready}      int32 accumulator beats, lane 0 in LSBs
//   res_t{data,valid,ready}      int8 residual beats, joined 1:1 with acc
//   out_t{data,valid,ready,last} OUT_W-bit signed sums; last marks the final beat of a row
//   busy, done, sat_count        status; done is a 1-cycle end-of-run pulse

// Per-lane 3-stage datapath: multiply, round/shift/saturate, residual add.
// Ports: adv_i stage enable, acc_i/res_i lane inputs, m_i/e_i latched params,
//        sat_o clip flag of the beat currently in stage 2, out_o stage-3 sum.
module self_output_residual_requant_lane #(
    parameter int D_W     = 8,
    parameter int D_W_ACC = 32,
    parameter int OUT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      adv_i,
    input  logic signed [D_W_ACC-1:0] acc_i,
    input  logic signed [D_W-1:0]     res_i,
    input  logic [31:0]               m_i,
    input  logic [5:0]                e_i,
    output logic                      sat_o,
    output logic [OUT_W-1:0]          out_o
);
    // signed(acc) x unsigned(m) always fits in D_W_ACC+32 signed bits
    localparam int P_W = D_W_ACC + 32;

    logic signed [P_W-1:0]   acc_x, m_x, p_d, p_q;
    logic signed [P_W:0]     rnd, biased, shifted;
    logic                    clip_hi, clip_lo;
    logic signed [D_W-1:0]   q8_d, q8_q, res1_q, res2_q;
    logic signed [OUT_W-1:0] out_d, out_q;

    // S1: full-width product, operands widened so the result is exact
    always_comb begin
        acc_x = {{32{acc_i[D_W_ACC-1]}}, acc_i};
        m_x   = {{D_W_ACC{1'b0}}, m_i};
        p_d   = acc_x * m_x;
    end

    // S2: add half an LSB then arithmetic shift = round half toward +inf.
    // One guard bit keeps the bias add from overflowing for large products.
    always_comb begin
        rnd = '0;
        if (e_i != 6'd0) rnd = {{P_W{1'b0}}, 1'b1} << (e_i - 6'd1);
        biased  = {p_q[P_W-1], p_q} + rnd;
        shifted = biased >>> e_i;
        clip_hi = !shifted[P_W] && (shifted[P_W-1:D_W-1] != '0);
        clip_lo =  shifted[P_W] && (shifted[P_W-1:D_W-1] != '1);
        if (clip_hi)      q8_d = {1'b0, {(D_W-1){1'b1}}};
        else if (clip_lo) q8_d = {1'b1, {(D_W-1){1'b0}}};
        else              q8_d = shifted[D_W-1:0];
        sat_o = clip_hi | clip_lo;
    end

    // S3: sign-extended residual add
    always_comb begin
        out_d = {{(OUT_W-D_W){q8_q[D_W-1]}}, q8_q} + {{(OUT_W-D_W){res2_q[D_W-1]}}, res2_q};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            p_q    <= '0;
            res1_q <= '0;
            q8_q   <= '0;
            res2_q <= '0;
            out_q  <= '0;
        end else if (adv_i) begin
            p_q    <= p_d;
            res1_q <= res_i;
            q8_q   <= q8_d;
            res2_q <= res1_q;
            out_q  <= out_d;
        end
    end

    assign out_o = out_q;
endmodule

module self_output_residual_requant #(
    parameter int TOKENS  = 128,
    parameter int EMBED   = 768,
    parameter int LANES   = 4,
    parameter int D_W     = 8,
    parameter int D_W_ACC = 32,
    parameter int OUT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       start,
    input  logic [31:0]                requant_m,
    input  logic [7:0]                 requant_e,
    input  logic [LANES*D_W_ACC-1:0]   acc_tdata,
    input  logic                       acc_tvalid,
    output logic                       acc_tready,
    input  logic [LANES*D_W-1:0]       res_tdata,
    input  logic                       res_tvalid,
    output logic                       res_tready,
    output logic [LANES*OUT_W-1:0]     out_tdata,
    output logic                       out_tvalid,
    input  logic                       out_tready,
    output logic                       out_tlast,
    output logic                       busy,
    output logic                       done,
    output logic [15:0]                sat_count
);
    localparam int STAGES = 3;
    localparam int BPR    = EMBED / LANES;            // beats per row
    localparam int TOTAL  = TOKENS * BPR;             // beats per run
    localparam int CW     = $clog2(TOTAL + 1);
    localparam int RW     = (BPR > 1) ? $clog2(BPR) : 1;
    localparam int SW     = $clog2(LANES + 1);
    localparam logic [CW-1:0] BEAT_LAST = CW'(TOTAL - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(BPR - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [31:0]       m_q, m_d;
    logic [5:0]        e_q, e_d;
    logic [CW-1:0]     in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
    logic [RW-1:0]     row_cnt_q, row_cnt_d;
    logic [15:0]       sat_q, sat_d;
    logic [STAGES:1]   vld_pipe_q;
    logic [LANES-1:0]  sat_lane;
    logic [SW-1:0]     sat_inc;
    logic [16:0]       sat_sum;
    logic              run, adv, fire, out_hs;

    assign run    = (state_q == S_RUN);
    // Global stall: every stage holds while the output beat is not taken
    assign adv    = !out_tvalid | out_tready;
    assign fire   = run & acc_tvalid & res_tvalid & adv;
    assign out_hs = out_tvalid & out_tready;

    assign acc_tready = run & res_tvalid & adv;
    assign res_tready = run & acc_tvalid & adv;
    assign out_tvalid = vld_pipe_q[STAGES];
    assign out_tlast  = out_tvalid & (row_cnt_q == ROW_LAST);
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign sat_count  = sat_q;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        self_output_residual_requant_lane #(
            .D_W(D_W), .D_W_ACC(D_W_ACC), .OUT_W(OUT_W)
        ) u_lane (
            .clk   (clk),
            .rstn  (rstn),
            .adv_i (adv),
            .acc_i (acc_tdata[g*D_W_ACC +: D_W_ACC]),
            .res_i (res_tdata[g*D_W +: D_W]),
            .m_i   (m_q),
            .e_i   (e_q),
            .sat_o (sat_lane[g]),
            .out_o (out_tdata[g*OUT_W +: OUT_W])
        );
    end

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        e_d       = e_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        row_cnt_d = row_cnt_q;
        sat_d     = sat_q;

        // all lanes clipping in one beat add their full count at once
        sat_inc = '0;
        for (int i = 0; i < LANES; i++) sat_inc = sat_inc + SW'(sat_lane[i]);
        sat_sum = {1'b0, sat_q} + 17'(sat_inc);
        if (adv && vld_pipe_q[1]) sat_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];

        if (fire) in_cnt_d = in_cnt_q + CW'(1);
        // row framing follows the output side so stalls cannot skew it
        if (out_hs) begin
            out_cnt_d = out_cnt_q + CW'(1);
            row_cnt_d = (row_cnt_q == ROW_LAST) ? '0 : row_cnt_q + RW'(1);
        end

        case (state_q)
            S_IDLE: if (start) begin
                state_d   = S_RUN;
                m_d       = requant_m;
                e_d       = (requant_e > 8'd63) ? 6'd63 : requant_e[5:0];
                in_cnt_d  = '0;
                out_cnt_d = '0;
                row_cnt_d = '0;
                sat_d     = '0;
            end
            S_RUN:   if (fire && in_cnt_q == BEAT_LAST) state_d = S_DRAIN;
            S_DRAIN: if (out_hs && out_cnt_q == BEAT_LAST) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            m_q        <= '0;
            e_q        <= '0;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            row_cnt_q  <= '0;
            sat_q      <= '0;
            vld_pipe_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            e_q       <= e_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            row_cnt_q <= row_cnt_d;
            sat_q     <= sat_d;
            if (adv) vld_pipe_q <= {vld_pipe_q[STAGES-1:1], fire};
        end
    end
endmodule

// File: tb/tb_self_output_residual_requant.sv
`timescale 1ns/1ps
module tb_self_output_residual_requant;
    localparam int TOK = 2, EMB = 8, LANES = 4;
    localparam int BPR = EMB / LANES;
    localparam int NB  = TOK * BPR;

    logic clk, rstn, start;
    logic [31:0] requant_m;
    logic [7:0]  requant_e;
    logic [LANES*32-1:0] acc_tdata;
    logic [LANES*8-1:0]  res_tdata;
    logic [LANES*16-1:0] out_tdata;
    logic acc_tvalid, acc_tready, res_tvalid, res_tready;
    logic out_tvalid, out_tready, out_tlast, busy, done;
    logic [15:0] sat_count;

    int checks = 0, errors = 0;
    int cyc = 0, hs_cyc = 0, done_cyc = 0, done_cnt = 0;
    logic [LANES*16-1:0] outs[$];
    bit lasts[$];
    logic [LANES*32-1:0] acc_st[NB];
    logic [LANES*8-1:0]  res_st[NB];

    self_output_residual_requant #(
        .TOKENS(TOK), .EMBED(EMB), .LANES(LANES), .D_W(8), .D_W_ACC(32), .OUT_W(16)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start),
        .requant_m(requant_m), .requant_e(requant_e),
        .acc_tdata(acc_tdata), .acc_tvalid(acc_tvalid), .acc_tready(acc_tready),
        .res_tdata(res_tdata), .res_tvalid(res_tvalid), .res_tready(res_tready),
        .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready),
        .out_tlast(out_tlast), .busy(busy), .done(done), .sat_count(sat_count)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output/done capture on the falling edge; a sampled handshake completes at the next rise
    always @(negedge clk) begin
        if (rstn && out_tvalid && out_tready) begin
            outs.push_back(out_tdata);
            lasts.push_back(out_tlast);
            hs_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: exact arithmetic on wide integers straight from the requant rules
    function automatic logic [LANES*16-1:0] ref_beat(input logic [LANES*32-1:0] a,
            input logic [LANES*8-1:0] r, input logic [31:0] m, input logic [7:0] e,
            output int nsat);
        logic [LANES*16-1:0] o;
        o = '0;
        nsat = 0;
        for (int l = 0; l < LANES; l++) begin
            longint p;
            logic signed [95:0] w;
            int q, ec;
            p  = longint'($signed(a[l*32 +: 32])) * longint'({32'd0, m});
            ec = (e > 8'd63) ? 63 : int'(e);
            w  = p;
            if (ec > 0) w = (w + (96'sd1 <<< (ec - 1))) >>> ec;
            if (w > 127)       begin q = 127;  nsat++; end
            else if (w < -128) begin q = -128; nsat++; end
            else               q = int'(w);
            q = q + int'($signed(r[l*8 +: 8]));
            o[l*16 +: 16] = 16'(q);
        end
        return o;
    endfunction

    task automatic fill_const(input int a, input int r);
        for (int b = 0; b < NB; b++)
            for (int l = 0; l < LANES; l++) begin
                acc_st[b][l*32 +: 32] = a;
                res_st[b][l*8 +: 8]   = r[7:0];
            end
    endtask

    task automatic fill_rand();
        for (int b = 0; b < NB; b++) begin
            acc_st[b] = {$urandom, $urandom, $urandom, $urandom};
            res_st[b] = $urandom;
        end
    endtask

    task automatic do_start(input logic [31:0] m, input logic [7:0] e);
        @(posedge clk); #1;
        requant_m = m; requant_e = e; start = 1;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic drive(input string tag, input int n, input int skew);
        for (int b = 0; b < n; b++) begin
            int t;
            acc_tdata = acc_st[b]; res_tdata = res_st[b]; acc_tvalid = 1;
            if (b == 0 && skew > 0) begin
                res_tvalid = 0;
                repeat (skew) begin
                    @(negedge clk);
                    chk({tag, "_skew_acc_tready"}, acc_tready, 0);
                end
                @(posedge clk); #1;
            end
            res_tvalid = 1;
            t = 0;
            @(negedge clk);
            while (!(acc_tready && res_tready) && t < 100) begin @(negedge clk); t++; end
            if (t >= 100) begin chk({tag, "_hs_timeout"}, 0, 1); break; end
            @(posedge clk); #1;
        end
        acc_tvalid = 0; res_tvalid = 0;
    endtask

    task automatic stall5(input string tag);
        int t = 0;
        while (outs.size() < 1 && t < 200) begin @(negedge clk); t++; end
        @(posedge clk); #1;
        out_tready = 0;
        repeat (5) begin
            @(negedge clk);
            chk({tag, "_stall_acc_tready"}, acc_tready, 0);
            chk({tag, "_stall_out_tvalid"}, out_tvalid, 1);
        end
        @(posedge clk); #1;
        out_tready = 1;
    endtask

    task automatic run(input string tag, input logic [31:0] m, input logic [7:0] e,
                       input int skew, input bit stall, input bit mid);
        int exp_sat, ns, t;
        outs.delete(); lasts.delete(); done_cnt = 0;
        do_start(m, e);
        chk({tag, "_busy"}, busy, 1);
        fork
            drive(tag, NB, skew);
            begin if (stall) stall5(tag); end
            begin if (mid) begin
                repeat (2) @(posedge clk); #1;
                requant_m = ~m; requant_e = 8'd5; start = 1;
                @(posedge clk); #1;
                start = 0; requant_m = m; requant_e = e;
            end end
        join
        t = 0;
        while (done_cnt == 0 && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) chk({tag, "_done_timeout"}, 0, 1);
        repeat (3) @(negedge clk);
        chk({tag, "_nbeats"}, outs.size(), NB);
        exp_sat = 0;
        for (int b = 0; b < NB; b++) begin
            logic [LANES*16-1:0] ex;
            ex = ref_beat(acc_st[b], res_st[b], m, e, ns);
            exp_sat += ns;
            if (b < outs.size()) begin
                chk($sformatf("%s_data%0d", tag, b), outs[b], ex);
                chk($sformatf("%s_last%0d", tag, b), lasts[b], (b % BPR) == BPR - 1);
            end
        end
        chk({tag, "_sat"}, sat_count, (exp_sat > 65535) ? 65535 : exp_sat);
        chk({tag, "_done_once"}, done_cnt, 1);
        chk({tag, "_done_time"}, done_cyc, hs_cyc + 1);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        rstn = 0; start = 0; requant_m = 0; requant_e = 0;
        acc_tdata = 0; acc_tvalid = 0; res_tdata = 0; res_tvalid = 0; out_tready = 1;
        repeat (3) @(posedge clk); #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_out_tvalid", out_tvalid, 0);
        chk("rst_sat", sat_count, 0);
        chk("rst_acc_tready", acc_tready, 0);
        @(negedge clk); rstn = 1;

        // int8 requant of -300 at scale 2^-2: -75, plus residual 10
        fill_const(-300, 10);
        run("basic", 32'h4000_0000, 8'd32, 0, 0, 0);
        chk("basic_lane0", outs[0][15:0], 16'hFFBF);

        fill_const(1000, -3);
        run("satur", 32'h4000_0000, 8'd31, 0, 0, 0);
        chk("satur_lane0", outs[NB-1][15:0], 16'd124);
        chk("satur_cnt", sat_count, 16);

        for (int b = 0; b < NB; b++) begin
            acc_st[b] = {32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFD, 32'd3};
            res_st[b] = '0;
        end
        run("round", 32'd1, 8'd1, 0, 0, 0);
        chk("round_beat0", outs[0], {16'd0, 16'd1, 16'hFFFF, 16'd2});

        fill_const(5, 0);
        run("e0", 32'd2, 8'd0, 0, 0, 0);
        chk("e0_lane0", outs[0][15:0], 16'd10);

        fill_rand();
        begin
            logic [31:0] m; logic [7:0] e;
            m = $urandom_range(1, 255); e = 8'($urandom_range(30, 40));
            run("skew", m, e, 3, 0, 0);
            run("stall", m, e, 0, 1, 0);
        end

        fill_rand();
        run("midstart", 32'($urandom_range(1, 65535)), 8'($urandom_range(20, 36)), 0, 0, 1);

        fill_rand();
        run("clamp", $urandom, 8'd200, 0, 0, 0);

        // reset mid-run after two beats accepted
        fill_const(1000, 0);
        done_cnt = 0;
        do_start(32'h4000_0000, 8'd31);
        drive("rstmid", 2, 0);
        chk("rstmid_pre_sat_nz", sat_count != 0, 1);
        #2 rstn = 0;
        #1;
        chk("rstmid_busy", busy, 0);
        chk("rstmid_out_tvalid", out_tvalid, 0);
        chk("rstmid_sat", sat_count, 0);
        repeat (4) @(negedge clk);
        chk("rstmid_no_done", done_cnt, 0);
        rstn = 1;

        fill_const(-300, 10);
        run("after_rst", 32'h4000_0000, 8'd32, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
